// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-wide RAM port between the icache and dcache.
// Zero-latency combinational grant with dcache priority, dcache block-transfer
// lock, an icache starvation bound and a sticky bus-error flag.
`timescale 1ns/1ps
module memory_arbiter #(
    parameter int unsigned BURST_LEN   = 2,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    localparam int unsigned BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned SCW = $clog2(MAX_DSTREAK + 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);
    localparam logic [SCW-1:0] STREAK_MAX = SCW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t         owner_q, owner_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [SCW-1:0] dstreak_q, dstreak_d;
    logic           bus_err_q, bus_err_d;

    owner_t g;
    logic   d_req;
    logic   d_done;
    logic   i_done;
    logic   burst_end;

    assign d_req = dREN | dWEN;

    // Effective grant: held owner first, else dcache unless icache is owed a turn.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        g = OWN_NONE;
        if (RST) begin
            // Reset clears the flops asynchronously, but the grant is combinational
            // from the requests, so it is forced idle here to keep strobes low.
            g = OWN_NONE;
        end else if (owner_q != OWN_NONE) begin
            g = owner_q;
        end else if (d_req && !(iREN && dstreak_q == STREAK_MAX)) begin
            g = OWN_D;
        end else if (iREN) begin
            g = OWN_I;
        end
    end

    assign d_done    = (g == OWN_D) && (ramstate == RAM_ACCESS) && d_req;
    assign i_done    = (g == OWN_I) && (ramstate == RAM_ACCESS) && iREN;
    assign burst_end = d_done && (burst_cnt_q == BURST_LAST);

    // RAM port drive follows the granted requester's live inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        unique case (g)
            OWN_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            OWN_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            default: ;
        endcase
    end

    assign iwait   = ~i_done;
    assign dwait   = ~d_done;
    assign iload   = ramload;
    assign dload   = ramload;
    assign bus_err = bus_err_q;

    // Next owner, burst position, starvation streak and sticky error flag.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        dstreak_d   = dstreak_q;
        bus_err_d   = bus_err_q | ((g != OWN_NONE) && (ramstate == RAM_ERROR));

        if (d_done) begin
            if (burst_end) begin
                owner_d     = OWN_NONE;
                burst_cnt_d = '0;
            end else begin
                owner_d     = OWN_D;
                burst_cnt_d = burst_cnt_q + BCW'(1);
            end
        end else if (i_done) begin
            owner_d = OWN_NONE;
        end else if (g == OWN_D && d_req) begin
            owner_d = OWN_D;
        end else if (g == OWN_I && iREN) begin
            owner_d = OWN_I;
        end else begin
            // Request withdrawn (or nothing granted): abandon any partial burst.
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
        end

        if (!iREN || i_done) begin
            dstreak_d = '0;
        end else if (burst_end && dstreak_q != STREAK_MAX) begin
            dstreak_d = dstreak_q + SCW'(1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            dstreak_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            dstreak_q   <= dstreak_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: default instance plus a
// MAX_DSTREAK=2 instance for the starvation bound.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Default instance signals
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    // MAX_DSTREAK=2 instance signals
    logic        iREN_b, dREN_b, dWEN_b;
    logic [31:0] iaddr_b, daddr_b, dstore_b, ramload_b;
    logic [1:0]  ramstate_b;
    logic        iwait_b, dwait_b, ramREN_b, ramWEN_b, bus_err_b;
    logic [31:0] iload_b, dload_b, ramaddr_b, ramstore_b;

    memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    memory_arbiter #(.BURST_LEN(2), .MAX_DSTREAK(2)) dut_b (
        .CLK(CLK), .RST(RST),
        .iREN(iREN_b), .iaddr(iaddr_b), .iwait(iwait_b), .iload(iload_b),
        .dREN(dREN_b), .dWEN(dWEN_b), .daddr(daddr_b), .dstore(dstore_b),
        .dwait(dwait_b), .dload(dload_b),
        .ramREN(ramREN_b), .ramWEN(ramWEN_b), .ramaddr(ramaddr_b), .ramstore(ramstore_b),
        .ramload(ramload_b), .ramstate(ramstate_b), .bus_err(bus_err_b)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic idle();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = ST_FREE;
    endtask

    // Expected per-cycle waits for the MAX_DSTREAK=2 run: 2 D bursts, 1 I fetch, D again.
    int exp_dwait_b [6] = '{0, 0, 0, 0, 1, 0};
    int exp_iwait_b [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        idle();
        iREN_b = 0; dREN_b = 0; dWEN_b = 0;
        iaddr_b = 0; daddr_b = 0; dstore_b = 0; ramload_b = 0;
        ramstate_b = ST_FREE;

        // Reset: requests present and RAM ready, yet nothing may be driven.
        iREN = 1; dREN = 1; ramstate = ST_ACCESS; iaddr = 32'h10; daddr = 32'h20;
        sample();
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_iwait",  32'(iwait),  32'd1);
        check("rst_dwait",  32'(dwait),  32'd1);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        next_cycle();
        RST = 0;
        idle();

        // I fetch with two BUSY cycles then ACCESS.
        iREN = 1; iaddr = 32'h40; ramstate = ST_BUSY;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("ifetch_busy_ramREN", 32'(ramREN), 32'd1);
            check("ifetch_busy_addr",   ramaddr,     32'h40);
            check("ifetch_busy_iwait",  32'(iwait),  32'd1);
            next_cycle();
        end
        ramstate = ST_ACCESS; ramload = 32'hDEADBEEF;
        sample();
        check("ifetch_acc_ramREN", 32'(ramREN), 32'd1);
        check("ifetch_acc_iwait",  32'(iwait),  32'd0);
        check("ifetch_acc_iload",  iload,       32'hDEADBEEF);
        next_cycle();
        idle();
        sample();
        check("ifetch_after_ramREN", 32'(ramREN), 32'd0);
        check("ifetch_after_addr",   ramaddr,     32'h0);
        next_cycle();

        // I and D together: D block (0x80, 0x84) then I.
        iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h80;
        ramstate = ST_ACCESS; ramload = 32'hA0A0_0001;
        sample();
        check("prio_c0_dwait", 32'(dwait), 32'd0);
        check("prio_c0_iwait", 32'(iwait), 32'd1);
        check("prio_c0_addr",  ramaddr,    32'h80);
        check("prio_c0_dload", dload,      32'hA0A0_0001);
        next_cycle();
        daddr = 32'h84; ramload = 32'hA0A0_0002;
        sample();
        check("prio_c1_dwait", 32'(dwait), 32'd0);
        check("prio_c1_iwait", 32'(iwait), 32'd1);
        check("prio_c1_addr",  ramaddr,    32'h84);
        next_cycle();
        dREN = 0; ramload = 32'hA0A0_0003;
        sample();
        check("prio_c2_iwait", 32'(iwait), 32'd0);
        check("prio_c2_dwait", 32'(dwait), 32'd1);
        check("prio_c2_addr",  ramaddr,    32'h400);
        check("prio_c2_iload", iload,      32'hA0A0_0003);
        next_cycle();
        idle();
        next_cycle();

        // Write wins over read when both are asserted.
        dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'h12345678; ramstate = ST_BUSY;
        sample();
        check("wr_ramWEN",   32'(ramWEN), 32'd1);
        check("wr_ramREN",   32'(ramREN), 32'd0);
        check("wr_ramstore", ramstore,    32'h12345678);
        check("wr_ramaddr",  ramaddr,     32'h100);
        check("wr_dwait",    32'(dwait),  32'd1);
        next_cycle();
        idle();
        next_cycle();

        // Starvation bound on the MAX_DSTREAK=2 instance.
        iREN_b = 1; iaddr_b = 32'h300; dREN_b = 1; daddr_b = 32'h200; ramstate_b = ST_ACCESS;
        for (int c = 0; c < 6; c++) begin
            sample();
            check($sformatf("streak_c%0d_dwait", c), 32'(dwait_b), 32'(exp_dwait_b[c]));
            check($sformatf("streak_c%0d_iwait", c), 32'(iwait_b), 32'(exp_iwait_b[c]));
            check($sformatf("streak_c%0d_addr", c), ramaddr_b,
                  (exp_iwait_b[c] == 0) ? 32'h300 : 32'h200);
            next_cycle();
        end
        iREN_b = 0; dREN_b = 0; ramstate_b = ST_FREE;
        next_cycle();

        // Reset in the middle of a D burst.
        dREN = 1; daddr = 32'h180; ramstate = ST_ACCESS;
        sample();
        check("rstmid_w0_dwait", 32'(dwait), 32'd0);
        next_cycle();
        RST = 1;
        sample();
        check("rstmid_ramREN", 32'(ramREN), 32'd0);
        check("rstmid_dwait",  32'(dwait),  32'd1);
        next_cycle();
        RST = 0;
        sample();
        check("rstmid_new_w0_dwait", 32'(dwait), 32'd0);
        next_cycle();
        // Fresh burst still has one word to go, so the lock must hold off I.
        iREN = 1; iaddr = 32'h500; daddr = 32'h184;
        sample();
        check("rstmid_new_w1_dwait", 32'(dwait), 32'd0);
        check("rstmid_new_w1_iwait", 32'(iwait), 32'd1);
        next_cycle();
        dREN = 0;
        sample();
        check("rstmid_i_iwait", 32'(iwait), 32'd0);
        next_cycle();
        idle();
        next_cycle();

        // ERROR during an I grant.
        iREN = 1; iaddr = 32'h60; ramstate = ST_ERROR;
        sample();
        check("err_c0_iwait",   32'(iwait),   32'd1);
        check("err_c0_ramREN",  32'(ramREN),  32'd1);
        check("err_c0_bus_err", 32'(bus_err), 32'd0);
        next_cycle();
        ramstate = ST_BUSY;
        sample();
        check("err_c1_bus_err", 32'(bus_err), 32'd1);
        check("err_c1_iwait",   32'(iwait),   32'd1);
        check("err_c1_addr",    ramaddr,      32'h60);
        next_cycle();
        ramstate = ST_ACCESS;
        sample();
        check("err_c2_iwait", 32'(iwait), 32'd0);
        next_cycle();
        idle();
        next_cycle();
        sample();
        check("err_sticky_bus_err", 32'(bus_err), 32'd1);
        next_cycle();
        RST = 1;
        sample();
        check("err_cleared_bus_err", 32'(bus_err), 32'd0);
        next_cycle();
        RST = 0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
